// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel-rate divider, h/v counters, registered syncs and video_on aligned with pixel_x/pixel_y.
// Optional frame_count output is enabled by defining VGA_SYNC_FRAME_COUNT_EN.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
`ifdef VGA_SYNC_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Bounds are one bit wider so an end-exclusive limit of 1024 still fits.
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] HS_BEG   = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [3:0] div_cnt;
  logic [3:0] div_nxt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       wrap;

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
    h_nxt   = pixel_x;
    v_nxt   = pixel_y;
    wrap    = p_tick && (pixel_x == H_LAST) && (pixel_y == V_LAST);
    if (p_tick) begin
      if (pixel_x == H_LAST) begin
        h_nxt = 10'd0;
        v_nxt = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
      end else begin
        h_nxt = pixel_x + 10'd1;
      end
    end
  end

  // Sync/video flags are decoded from the next counter values so they land with the coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= 4'd0;
      p_tick      <= 1'b0;
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
`ifdef VGA_SYNC_FRAME_COUNT_EN
      frame_count <= 8'd0;
`endif
    end else begin
      div_cnt     <= div_nxt;
      p_tick      <= (div_nxt == DIV_LAST);
      pixel_x     <= h_nxt;
      pixel_y     <= v_nxt;
      hsync       <= !(({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END));
      vsync       <= !(({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END));
      video_on    <= ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
      frame_start <= wrap;
`ifdef VGA_SYNC_FRAME_COUNT_EN
      frame_count <= frame_count + {7'd0, wrap};
`endif
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: closed-form timing model checked every cycle on three parameter sets, plus literal pins.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int k = 0;
  bit rst_q = 1'b1;
  bit started = 1'b0;

  // Edges since the last edge that sampled reset high.
  always @(posedge clk) begin
    rst_q   <= reset;
    k       <= reset ? 0 : k + 1;
    started <= 1'b1;
  end

  logic       hs_d, vs_d, von_d, pt_d, fs_d; logic [9:0] x_d, y_d; logic [7:0] fc_d;
  logic       hs_s, vs_s, von_s, pt_s, fs_s; logic [9:0] x_s, y_s; logic [7:0] fc_s;
  logic       hs_t, vs_t, von_t, pt_t, fs_t; logic [9:0] x_t, y_t; logic [7:0] fc_t;

  vga_sync_gen u_def (
    .clk(clk), .reset(reset), .hsync(hs_d), .vsync(vs_d), .video_on(von_d), .p_tick(pt_d),
    .pixel_x(x_d), .pixel_y(y_d), .frame_start(fs_d)
`ifdef VGA_SYNC_FRAME_COUNT_EN
    , .frame_count(fc_d)
`endif
  );

  vga_sync_gen #(.CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) u_sml (
    .clk(clk), .reset(reset), .hsync(hs_s), .vsync(vs_s), .video_on(von_s), .p_tick(pt_s),
    .pixel_x(x_s), .pixel_y(y_s), .frame_start(fs_s)
`ifdef VGA_SYNC_FRAME_COUNT_EN
    , .frame_count(fc_s)
`endif
  );

  vga_sync_gen #(.CLK_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                 .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) u_tny (
    .clk(clk), .reset(reset), .hsync(hs_t), .vsync(vs_t), .video_on(von_t), .p_tick(pt_t),
    .pixel_x(x_t), .pixel_y(y_t), .frame_start(fs_t)
`ifdef VGA_SYNC_FRAME_COUNT_EN
    , .frame_count(fc_t)
`endif
  );

`ifndef VGA_SYNC_FRAME_COUNT_EN
  assign fc_d = 8'd0;
  assign fc_s = 8'd0;
  assign fc_t = 8'd0;
`endif

  // Expected outputs after kk edges out of reset: ticks seen so far give a linear pixel position.
  function automatic logic [32:0] model(int kk, bit rst, int d, int hd, int hf, int hs, int hb,
                                        int vd, int vf, int vs, int vb);
    int ht, vt, t, pos, x, y;
    logic hsn, vsn, von, pt, fs;
    logic [7:0] fc;
    if (rst) return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0};
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    t   = (d == 1) ? kk - 1 : kk / d;
    pos = t % (ht * vt);
    x   = pos % ht;
    y   = pos / ht;
    hsn = !(x >= hd + hf && x < hd + hf + hs);
    vsn = !(y >= vd + vf && y < vd + vf + vs);
    von = (x < hd) && (y < vd);
    pt  = (kk % d) == d - 1;
    fs  = (t > 0) && (pos == 0) && (((kk - 1) % d) == d - 1);
`ifdef VGA_SYNC_FRAME_COUNT_EN
    fc  = 8'((t / (ht * vt)) % 256);
`else
    fc  = 8'd0;
`endif
    return {hsn, vsn, von, pt, fs, 10'(x), 10'(y), fc};
  endfunction

  task automatic cmp(string nm, logic [32:0] act, logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("model_def", {hs_d, vs_d, von_d, pt_d, fs_d, x_d, y_d, fc_d},
          model(k, rst_q, 2, 640, 16, 96, 48, 480, 10, 2, 33));
      cmp("model_sml", {hs_s, vs_s, von_s, pt_s, fs_s, x_s, y_s, fc_s},
          model(k, rst_q, 3, 8, 2, 3, 2, 6, 2, 2, 3));
      cmp("model_tny", {hs_t, vs_t, von_t, pt_t, fs_t, x_t, y_t, fc_t},
          model(k, rst_q, 1, 4, 1, 2, 1, 3, 1, 1, 1));
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s k=%0d: got %0d expected %0d", nm, k, act, exp);
    end
  endtask

  task automatic run_to(int target);
    while (k < target) @(negedge clk);
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_hsync", hs_d, 1);   chk("rst_vsync", vs_d, 1);
    chk("rst_von", von_d, 0);    chk("rst_ptick", pt_d, 0);
    chk("rst_fs", fs_d, 0);      chk("rst_x", x_d, 0);   chk("rst_y", y_d, 0);
    chk("rst_tny_ptick", pt_t, 0);
    reset = 1'b0;

    run_to(1);    chk("rel_von", von_d, 1); chk("rel_x", x_d, 0); chk("rel_ptick", pt_d, 1);
                  chk("tny_ptick", pt_t, 1); chk("tny_x", x_t, 0);
    run_to(2);    chk("tick2_x", x_d, 1); chk("tick2_ptick", pt_d, 0); chk("tny_x2", x_t, 1);
    run_to(359);  chk("sml_vs_pre", vs_s, 1);
    run_to(360);  chk("sml_vs_fall", vs_s, 0); chk("sml_y_vs", y_s, 8);
    run_to(449);  chk("sml_vs_last", vs_s, 0);
    run_to(450);  chk("sml_vs_rise", vs_s, 1);
    run_to(584);  chk("sml_end_x", x_s, 14); chk("sml_end_y", y_s, 12); chk("sml_fs_pre", fs_s, 0);
    run_to(585);  chk("sml_wrap_x", x_s, 0); chk("sml_wrap_y", y_s, 0); chk("sml_fs", fs_s, 1);
    run_to(586);  chk("sml_fs_once", fs_s, 0);
    run_to(1279); chk("von_639", von_d, 1); chk("x_639", x_d, 639);
    run_to(1280); chk("von_640", von_d, 0); chk("x_640", x_d, 640);
    run_to(1311); chk("hs_655", hs_d, 1);
    run_to(1312); chk("hs_656", hs_d, 0); chk("x_656", x_d, 656);
    run_to(1503); chk("hs_751", hs_d, 0);
    run_to(1504); chk("hs_752", hs_d, 1);
    run_to(1598); chk("x_799", x_d, 799); chk("y_799", y_d, 0);
    run_to(1600); chk("line_x", x_d, 0); chk("line_y", y_d, 1); chk("line_fs", fs_d, 0);

    // Mid-frame reset on the small instance inside its hsync region.
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (x_s == 10'd12 && y_s == 10'd4) found = 1'b1;
    end
    chk("mid_found", int'(found), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_x", x_s, 0);   chk("mid_y", y_s, 0);   chk("mid_hs", hs_s, 1);
    chk("mid_vs", vs_s, 1); chk("mid_von", von_s, 0); chk("mid_fs", fs_s, 0);
    chk("mid_pt", pt_s, 0);
    run_to(1);  chk("mid_rel_x", x_s, 0); chk("mid_rel_von", von_s, 1); chk("mid_rel_fs", fs_s, 0);
    run_to(3);  chk("mid_cnt_x", x_s, 1);

    // Tiny instance: 48 ticks per frame, one tick per clk after the first.
    run_to(49);    chk("tny_fs1", fs_t, 1); chk("tny_x0", x_t, 0); chk("tny_y0", y_t, 0);
    run_to(50);    chk("tny_fs1_off", fs_t, 0);
`ifdef VGA_SYNC_FRAME_COUNT_EN
    chk("tny_fc1", fc_t, 1);
    run_to(97);    chk("tny_fc2", fc_t, 2); chk("tny_fs2", fs_t, 1);
    run_to(145);   chk("tny_fc3", fc_t, 3);
    run_to(12241); chk("tny_fc255", fc_t, 255); chk("tny_fs255", fs_t, 1);
    run_to(12288); chk("tny_fc255_hold", fc_t, 255);
    run_to(12289); chk("tny_fc_wrap", fc_t, 0); chk("tny_fs_wrap", fs_t, 1);
`else
    run_to(12289); chk("tny_fs_late", fs_t, 1);
`endif
    run_to(12290); chk("tny_fs_late_off", fs_t, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
